// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared constants and helpers for the sync_fifo_thresh slice: pointer width
// derivation, depth derivation and the reset values of the registered
// error pulses.
// Ports: none (package).
package sync_fifo_pkg;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam logic RST_OVERFLOW  = 1'b0;
  localparam logic RST_UNDERFLOW = 1'b0;

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// sync_fifo_thresh_if
// Producer/consumer bundle for sync_fifo_thresh.
// Ports (as signals):
//   wr_en, din          write request and data            (master -> slave)
//   rd_en               read request / pop                (master -> slave)
//   dout                read data                         (slave -> master)
//   full, empty, almost_full, almost_empty, count         status (slave -> master)
//   overflow, underflow one-cycle error pulses            (slave -> master)
interface sync_fifo_thresh_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              din;
  logic                               rd_en;
  logic [DATA_WIDTH-1:0]              dout;
  logic                               full;
  logic                               empty;
  logic                               almost_full;
  logic                               almost_empty;
  logic [ptr_width(ADDR_WIDTH)-1:0]   count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// Simple dual-port RAM: one write port, one read port.
// Read port is synchronous (registered, reset to 0, updates only when re)
// unless SYNC_FIFO_FWFT_EN is defined, in which case it is asynchronous.
// Ports:
//   clk, rst         clock, async active-high reset (read register only)
//   we, waddr, wdata write port
//   re, raddr        read enable / address
//   rdata            read data
// Storage itself is never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh
// Single-clock FIFO with exact full/empty (extra pointer bit), occupancy
// count, almost-full/almost-empty thresholds and registered overflow/
// underflow pulses.
// Compile option: SYNC_FIFO_FWFT_EN selects first-word-fall-through read
// data; undefined gives registered read data (1-cycle read latency).
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   sync_fifo_thresh_if.slave (wr_en/din/rd_en in; dout and status out)
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_thresh_if.slave  bus
);
  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_CMP  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_CMP = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // All status derives from registered pointers only.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.overflow  <= RST_OVERFLOW;
      bus.underflow <= RST_UNDERFLOW;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      bus.overflow  <= bus.wr_en && full;
      bus.underflow <= bus.rd_en && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is shown only while it is valid; stale RAM is masked.
  assign bus.dout = empty ? '0 : mem_rdata;
`else
  assign bus.dout = mem_rdata;
`endif

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AFULL_CMP);
  assign bus.almost_empty = (count <= AEMPTY_CMP);

endmodule

// File: tb/tb_sync_fifo_thresh.sv
module tb_sync_fifo_thresh;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_thresh_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_thresh #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf;
  logic       exp_udf;
  logic [39:0] w_pat;
  logic [39:0] r_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock with the given request; reference queue predicts everything.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    int n;
    logic fm, em;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    n  = q.size();
    fm = (n == DEPTH);
    em = (n == 0);
    exp_ovf = w && fm;
    exp_udf = r && em;
    if (r && !em) begin
`ifndef SYNC_FIFO_FWFT_EN
      exp_dout = q[0];
`endif
      void'(q.pop_front());
    end
    if (w && !fm) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = (q.size() != 0) ? q[0] : 8'h00;
`endif
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("m_count", bus.count, q.size());
    chk("m_dout", bus.dout, exp_dout);
    chk("m_full", bus.full, q.size() == DEPTH);
    chk("m_empty", bus.empty, q.size() == 0);
    chk("m_afull", bus.almost_full, q.size() >= AF);
    chk("m_aempty", bus.almost_empty, q.size() <= AE);
    chk("m_ovf", bus.overflow, exp_ovf);
    chk("m_udf", bus.underflow, exp_udf);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    exp_dout  = 8'h00;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_aempty", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_afull", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
    chk("rst_dout", bus.dout, 0);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 12) chk("afull_at13", bus.almost_full, 0);
      if (i == 13) chk("afull_at14", bus.almost_full, 1);
      if (i == 14) chk("full_at15", bus.full, 0);
    end
    chk("full16", bus.full, 1);
    chk("count16", bus.count, 16);

    cyc(1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count, 16);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", bus.overflow, 0);

    // Drain, checking order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_seq", bus.dout, (i < 15) ? i + 1 : 0);
`else
      chk("rd_seq", bus.dout, i);
`endif
      if (i == 12) chk("aempty_at3", bus.almost_empty, 0);
      if (i == 13) chk("aempty_at2", bus.almost_empty, 1);
    end
    chk("empty_after", bus.empty, 1);

    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", bus.underflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("dout_empty", bus.dout, 8'h00);
`else
    chk("dout_hold", bus.dout, 8'h0F);
`endif
    cyc(1'b0, 1'b0, 8'h00);
    chk("udf_clear", bus.underflow, 0);

    // Simultaneous read+write when empty: write wins.
    cyc(1'b1, 1'b1, 8'h55);
    chk("sim_empty_count", bus.count, 1);
    chk("sim_empty_udf", bus.underflow, 1);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    chk("refill_count", bus.count, 16);

    // Simultaneous read+write when full: read wins.
    cyc(1'b1, 1'b1, 8'hEF);
    chk("sim_full_count", bus.count, 15);
    chk("sim_full_ovf", bus.overflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_full_dout", bus.dout, 8'h60);
`else
    chk("sim_full_dout", bus.dout, 8'h55);
`endif
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("drain_empty", bus.empty, 1);

    // Interleaved traffic across pointer wrap.
    w_pat = 40'hDB_6F_5A_B7_ED;
    r_pat = 40'h6D_B5_AF_5B_3A;
    for (int i = 0; i < 40; i++) cyc(w_pat[i], r_pat[i], 8'(8'h80 + i));
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("mix_empty", bus.empty, 1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_rst_count", bus.count, 9);
    bus.wr_en = 1'b1;
    bus.din   = 8'h3F;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    q.delete();
    exp_dout = 8'h00;
    chk("mrst_count", bus.count, 0);
    chk("mrst_empty", bus.empty, 1);
    chk("mrst_aempty", bus.almost_empty, 1);
    chk("mrst_full", bus.full, 0);
    chk("mrst_afull", bus.almost_full, 0);
    chk("mrst_dout", bus.dout, 0);
    chk("mrst_ovf", bus.overflow, 0);
    chk("mrst_udf", bus.underflow, 0);

    cyc(1'b1, 1'b0, 8'hC0);
    cyc(1'b1, 1'b0, 8'hC1);
    cyc(1'b0, 1'b1, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
    chk("resume_dout", bus.dout, 8'hC1);
`else
    chk("resume_dout", bus.dout, 8'hC0);
`endif
    cyc(1'b0, 1'b1, 8'h00);
    chk("resume_empty", bus.empty, 1);

    // Single word into an empty FIFO, then pop.
    cyc(1'b1, 1'b0, 8'hA5);
`ifdef SYNC_FIFO_FWFT_EN
    chk("a5_shown", bus.dout, 8'hA5);
`else
    chk("a5_not_yet", bus.dout, 8'hC1);
`endif
    cyc(1'b0, 1'b1, 8'h00);
    chk("a5_empty", bus.empty, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("a5_popped", bus.dout, 8'h00);
`else
    chk("a5_read", bus.dout, 8'hA5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
